// File: rtl/adder_pkg.sv
// Shared types and constants for the serial chunked add/subtract unit.
// Mode encoding for the 'sub' input and the two-state sequencer.
package adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/rca_chunk.sv
// Purely combinational CHUNK-bit ripple-carry slice built from per-bit full adders.
// Exposes the carry into the top bit so the caller can derive signed overflow.
module rca_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit add/subtract: one CHUNK-bit ripple slice reused for
// WIDTH/CHUNK cycles, carry held in a register between cycles.
module serial_chunk_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NCHUNK - 1);

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   idx;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  acc;
    logic              carry;

    logic [CHUNK-1:0]  a_sl;
    logic [CHUNK-1:0]  b_sl;
    logic [CHUNK-1:0]  s_sl;
    logic              c_out_sl;
    logic              c_msb_sl;
    logic              last;
    logic [WIDTH-1:0]  result;

    // Chunk selection and the accumulator with the current chunk merged in.
    always_comb begin
        a_sl   = a_q[int'(idx)*CHUNK +: CHUNK];
        b_sl   = b_q[int'(idx)*CHUNK +: CHUNK];
        last   = (idx == LAST);
        result = acc;
        result[int'(idx)*CHUNK +: CHUNK] = s_sl;
    end

    rca_chunk #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a        (a_sl),
        .b        (b_sl),
        .cin      (carry),
        .s        (s_sl),
        .cout     (c_out_sl),
        .c_msb_in (c_msb_sl)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: next-state gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // NOTE: operand and accumulator registers are reset too, so an aborted
    // operation leaves no stale data visible after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Subtraction is a + ~b + ~borrow through the same slice.
                        a_q   <= a;
                        b_q   <= (sub == SUB) ? ~b : b;
                        carry <= (sub == SUB) ? ~cin : cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    acc   <= result;
                    carry <= c_out_sl;
                    if (last) begin
                        idx  <= '0;
                        sum  <= result;
                        cout <= c_out_sl;
                        ovf  <= c_msb_sl ^ c_out_sl;
                        done <= 1'b1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three instances (CHUNK 4, 16, 1 at WIDTH 16)
// checked every cycle against an arithmetic model plus hand-computed vectors.
module tb_serial_chunk_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;

    logic [2:0]   busy_v;
    logic [2:0]   done_v;
    logic [2:0]   cout_v;
    logic [2:0]   ovf_v;
    logic [W-1:0] sum_v [3];

    int n_total = 0;
    int n_pass  = 0;
    bit cmp_en  = 0;
    int n_lat [3];

    // Model state: remaining cycles per instance, visible results, pending result.
    int           m_rem  [3];
    bit           m_done [3];
    logic [W-1:0] m_sum  [3];
    bit           m_cout [3];
    bit           m_ovf  [3];
    logic [W-1:0] p_sum  [3];
    logic         p_cout [3];
    logic         p_ovf  [3];

    serial_chunk_adder #(.WIDTH(W), .CHUNK(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
    );

    serial_chunk_adder #(.WIDTH(W), .CHUNK(16)) dut_c16 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
    );

    serial_chunk_adder #(.WIDTH(W), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Result from plain integer arithmetic: unsigned for sum/cout, signed for overflow.
    function automatic void calc(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic ci, input logic md,
                                 output logic [W-1:0] s, output logic co, output logic ov);
        int ux = int'(x);
        int uy = int'(y);
        int sx = int'($signed(x));
        int sy = int'($signed(y));
        int c  = int'(ci);
        int t;
        if (!md) begin
            s  = W'(ux + uy + c);
            co = (ux + uy + c) >= (1 << W);
            t  = sx + sy + c;
        end else begin
            s  = W'(ux - uy - c);
            co = ux >= (uy + c);
            t  = sx - sy - c;
        end
        ov = (t > 32767) || (t < -32768);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                m_rem[i] = 0; m_done[i] = 0; m_sum[i] = '0; m_cout[i] = 0; m_ovf[i] = 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] = 0;
                if (m_rem[i] > 0) begin
                    m_rem[i]--;
                    if (m_rem[i] == 0) begin
                        m_done[i] = 1;
                        m_sum[i]  = p_sum[i];
                        m_cout[i] = p_cout[i];
                        m_ovf[i]  = p_ovf[i];
                    end
                end else if (start) begin
                    calc(a, b, cin, sub, p_sum[i], p_cout[i], p_ovf[i]);
                    m_rem[i] = n_lat[i];
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("busy[%0d]", i), busy_v[i], m_rem[i] != 0);
                check($sformatf("done[%0d]", i), done_v[i], m_done[i]);
                check($sformatf("sum[%0d]",  i), sum_v[i],  m_sum[i]);
                check($sformatf("cout[%0d]", i), cout_v[i], m_cout[i]);
                check($sformatf("ovf[%0d]",  i), ovf_v[i],  m_ovf[i]);
            end
        end
    end

    task automatic drive_start(input logic [W-1:0] va, input logic [W-1:0] vb,
                               input logic vcin, input logic vsub);
        @(posedge clk); #1;
        a = va; b = vb; cin = vcin; sub = vsub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    endtask

    task automatic wait_done(input int i, input int max_cyc, output int n);
        n = -1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (done_v[i]) begin
                n = k;
                break;
            end
        end
        if (n < 0) check($sformatf("timeout[%0d]", i), 32'd0, 32'd1);
    endtask

    task automatic run_vec(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                           input logic vcin, input logic vsub,
                           input logic [W-1:0] esum, input logic ecout, input logic eovf);
        int lat [3];
        drive_start(va, vb, vcin, vsub);
        for (int i = 0; i < 3; i++) lat[i] = -1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (done_v[i] && lat[i] < 0) begin
                    lat[i] = k - 1;
                    check($sformatf("%s sum[%0d]",  tag, i), sum_v[i],  esum);
                    check($sformatf("%s cout[%0d]", tag, i), cout_v[i], ecout);
                    check($sformatf("%s ovf[%0d]",  tag, i), ovf_v[i],  eovf);
                end
            end
        end
        for (int i = 0; i < 3; i++)
            check($sformatf("%s latency[%0d]", tag, i), lat[i], n_lat[i]);
    endtask

    initial begin
        int  n;
        bit  seen_done;
        n_lat[0] = 4; n_lat[1] = 1; n_lat[2] = 16;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        #1;
        check("reset busy", busy_v, 3'b000);
        check("reset done", done_v, 3'b000);
        check("reset sum0", sum_v[0], 16'h0000);
        check("reset cout", cout_v, 3'b000);
        check("reset ovf",  ovf_v,  3'b000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        cmp_en = 1'b1;
        repeat (2) @(negedge clk);
        check("idle busy", busy_v, 3'b000);
        check("idle sum0", sum_v[0], 16'h0000);

        run_vec("add1234", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
        run_vec("addffff", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_vec("add7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_vec("sub8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        run_vec("sub0003", 16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0);
        run_vec("add8000", 16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1);
        run_vec("sub5555", 16'h5555, 16'h5555, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        run_vec("add0f0f", 16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

        // Start while busy is ignored; start in the done cycle is accepted.
        drive_start(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(posedge clk); #1;
        a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, 10, n);
        check("busy-start done time", n, 3);
        check("busy-start sum0", sum_v[0], 16'h2345);
        a = 16'h0F0F; b = 16'h00F1; cin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, 10, n);
        check("b2b latency", n - 1, 4);
        check("b2b sum0", sum_v[0], 16'h1001);
        check("b2b cout0", cout_v[0], 1'b0);
        wait_done(2, 20, n);
        check("busy-start sum2", sum_v[2], 16'h2345);
        repeat (4) @(negedge clk);

        // Reset two cycles into RUN aborts without a done pulse.
        drive_start(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("abort busy", busy_v, 3'b000);
        check("abort done", done_v, 3'b000);
        check("abort sum0", sum_v[0], 16'h0000);
        check("abort sum2", sum_v[2], 16'h0000);
        check("abort cout", cout_v, 3'b000);
        check("abort ovf",  ovf_v,  3'b000);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done_v != 3'b000) seen_done = 1'b1;
        end
        check("abort no done", seen_done, 1'b0);
        run_vec("post-rst", 16'hABCD, 16'h1234, 1'b1, 1'b1, 16'h9998, 1'b1, 1'b0);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/serial_chunk_adder.md
Name: serial_chunk_adder

Overview:
- Parametrised multi-cycle add/subtract unit; the next generation of the team's 4-bit ripple-carry adder.
- Processes a WIDTH-bit operand pair CHUNK bits per clock through one combinational CHUNK-bit ripple slice, carrying between cycles in a register.
- Trades latency for area in datapaths where a full-width ripple chain misses timing; start/busy/done handshake to the controlling FSM.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK (localparam), WIDTH/CHUNK, number of RUN cycles.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; sampled with start
- b  input  WIDTH  operand B; sampled with start
- cin  input  1  carry-in (ADD) / borrow-in (SUB); sampled with start
- sub  input  1  0 = ADD a+b+cin, 1 = SUB a-b-cin; sampled with start
- busy  output  1  high while operation in progress
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  result
- cout  output  1  raw carry out of MSB
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, internal counter/operand/carry regs=0. Reset mid-operation aborts; no done pulse.
- States: IDLE, RUN. Chunk counter idx 0..NCHUNK-1.
- IDLE, start=1 at edge E0: latch a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin, sub flag; idx=0; -> RUN; busy=1 from E0.
- RUN, edge Ek (k=1..NCHUNK): slice computes a[chunk idx] + b_eff[chunk idx] + carry; result chunk written to internal accumulator, carry register updated, idx++.
- At edge E(NCHUNK): sum <= full accumulated result, cout <= final carry, ovf <= carry into MSB XOR carry out of MSB; done=1 for the following cycle; busy=0; -> IDLE.
- Latency: done high exactly NCHUNK cycles after the start edge; throughput one operation per NCHUNK cycles (start may be asserted in the same cycle done is high and is accepted).
- sum/cout/ovf change only at the completion edge; held stable between operations and throughout busy.
- start while busy: ignored, no queueing; operand changes during busy have no effect.
- SUB: cout=1 means no borrow (a >= b+cin unsigned); cout=0 means borrow.
- CHUNK=WIDTH legal: NCHUNK=1, done one cycle after start.
- All arithmetic modulo 2^WIDTH; no saturation.

Decomposition:
- Package adder_pkg: mode constants ADD=1'b0, SUB=1'b1; state enum IDLE/RUN.
- Sub-module rca_chunk (parameter CHUNK): purely combinational CHUNK-bit ripple-carry adder, ports a, b, cin, s, cout, plus c_msb_in (carry into top bit) for overflow; built from per-bit full-adder equations. One instance in serial_chunk_adder.

Test Plan (WIDTH=16, CHUNK=4, NCHUNK=4):
- Reset then idle -> busy=0, done=0, sum=0x0000, cout=0, ovf=0; start pulse a=0x1234 b=0x1111 cin=0 sub=0 -> busy 4 cycles, done pulse 4 cycles after start edge, sum=0x2345, cout=0, ovf=0.
- ADD a=0xFFFF b=0x0001 cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples across all chunk boundaries).
- ADD a=0x7FFF b=0x0001 -> sum=0x8000, cout=0, ovf=1; SUB a=0x8000 b=0x0001 cin=0 -> sum=0x7FFF, cout=1, ovf=1.
- SUB a=0x0003 b=0x0005 cin=1 -> sum=0xFFFD, cout=0 (borrow), ovf=0.
- start re-asserted with different operands during busy -> ignored, first result unchanged; start asserted in done cycle -> accepted, second done 4 cycles later, back-to-back.
- rst_n asserted at cycle 2 of RUN -> all outputs 0 immediately, no done pulse; next operation after release correct. Repeat one sweep with CHUNK=16 and CHUNK=1 for latency 1 and 16.
